sb_tx_arbiter: RTL

SB_TX_ARBITER -- requirements
Module: sb_tx_arbiter

---
 rtl/sb_tx_pkg.sv | 12 +
 rtl/sb_rr_pick.sv | 31 +++
 rtl/sb_tx_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sb_tx_pkg.sv
// Shared types and constants for the SB transmit arbiter.
package sb_tx_pkg;

    localparam int SB_DW_DEFAULT = 416;
    localparam int SB_DEST_W     = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N, returned one-hot.
module sb_rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        logic [PW:0] idx;
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!any && req[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                any                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sb_tx_arbiter.sv
// Merges N SB input streams into one registered stream for the TX queue
// writer. Grants are message-granular and rotate round-robin.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | no grant held; a new stream may be picked this cycle
//   LOCKED | grant held on stream g_q until its last word is accepted
module sb_tx_arbiter
    import sb_tx_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = SB_DW_DEFAULT
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic [N*DW-1:0]        in_data,
    input  logic [N*SB_DEST_W-1:0] in_dest,
    input  logic [N-1:0]           in_last,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_ready,
    output logic [DW-1:0]          out_data,
    output logic [SB_DEST_W-1:0]   out_dest,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   en,
    output logic                   status_idle
);

    localparam int PW = $clog2(N);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] g_q, g_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  pick_oh;
    logic          pick_any;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] cur_g;
    logic          grant_act;
    logic          load_ok;
    logic          accept;
    logic          acc_last;

    sb_rr_pick #(.N(N)) u_pick (
        .req   (in_valid),
        .ptr   (ptr_q),
        .grant (pick_oh),
        .any   (pick_any)
    );

    // One-hot pick to stream index.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_oh[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    // A fresh pick is usable in the cycle it is made, so the active grant is
    // either the held one or the picker's choice.
    assign cur_g     = (state_q == LOCKED) ? g_q : pick_idx;
    assign grant_act = (state_q == LOCKED) || (en && pick_any);
    assign load_ok   = !out_valid || out_ready;
    assign accept    = grant_act && load_ok && in_valid[cur_g];
    assign acc_last  = accept && in_last[cur_g];

    // Ready only toward the granted stream; forced low while in reset so
    // nothing upstream believes a word was taken.
    always_comb begin
        in_ready = '0;
        if (grant_act && load_ok && nreset) begin
            in_ready[cur_g] = 1'b1;
        end
    end

    // Next-state: lock on grant, release and advance ptr after the last word.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        if (grant_act) begin
            if (acc_last) begin
                state_d = IDLE;
                ptr_d   = (cur_g == PW'(N-1)) ? '0 : cur_g + PW'(1);
            end else begin
                state_d = LOCKED;
                g_d     = cur_g;
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
        end
    end

    // Single output register: load on accept, otherwise drain when taken.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dest  <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(cur_g)*DW +: DW];
            out_dest  <= in_dest[int'(cur_g)*SB_DEST_W +: SB_DEST_W];
            out_last  <= in_last[cur_g];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign status_idle = (state_q == IDLE) && !out_valid;

endmodule
